// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, derived active-area origin and
// the capture FSM state type for the VGA receive path.
package vga_timing_pkg;

    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;

    localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BP;
    localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchroniser for the five VGA pins plus hsync falling-edge
// detection; all pins share one chain so colour stays aligned with sync.
module vga_sync_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] pins,
    output logic [4:0] sync,
    output logic       hsync_fall
);

    logic [4:0] s1;
    logic [4:0] s2;
    logic       s3;

    // Reset to 0 so a released reset never fakes an hsync fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= 1'b0;
        end else begin
            s1 <= pins;
            s2 <= s1;
            s3 <= s2[4];
        end
    end

    assign sync       = s2;
    assign hsync_fall = s3 & ~s2[4];

endmodule

// File: rtl/vga_rx_capture.sv
// VGA capture front end: recovers h/v position, locks to frame timing and
// emits active pixels. Optional err_count output: define VGA_RX_ERR_CNT_EN.
module vga_rx_capture
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vga_hsync,
    input  logic       vga_vsync,
    input  logic       vga_red,
    input  logic       vga_green,
    input  logic       vga_blue,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_rgb,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err
`ifdef VGA_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [9:0] H_A0   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_A1   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_A0   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_A1   = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [4:0] pins_s;
    logic       hs_fall;
    logic       vs_s;
    logic [2:0] rgb_s;

    vga_sync_edge u_sync (
        .clk       (clk),
        .reset     (reset),
        .pins      ({vga_hsync, vga_vsync, vga_red, vga_green, vga_blue}),
        .sync      (pins_s),
        .hsync_fall(hs_fall)
    );

    assign vs_s  = pins_s[3];
    assign rgb_s = pins_s[2:0];

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       vs_prev;
    logic [2:0] rgb_d;

    logic vs_start;
    logic line_fail;
    logic frame_ok;

    assign vs_start  = hs_fall & vs_prev & ~vs_s;
    assign line_fail = hs_fall & (h_cnt != H_LAST);
    assign frame_ok  = (v_cnt == V_LAST);

    // rgb_d keeps colour in step with the counters it is judged against
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            vs_prev <= 1'b0;
            rgb_d   <= '0;
        end else begin
            rgb_d <= rgb_s;
            if (hs_fall) begin
                h_cnt   <= '0;
                vs_prev <= vs_s;
                v_cnt   <= vs_start ? '0 : sat_inc(v_cnt);
            end else begin
                h_cnt <= sat_inc(h_cnt);
            end
        end
    end

    rx_state_t state;
    rx_state_t state_nx;
    logic      err_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    // Line check outranks the frame check on a shared sample
    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vs_start) begin
                    state_nx = VERIFY;
                end
            end
            VERIFY: begin
                if (line_fail) begin
                    state_nx = SEARCH;
                    err_nx   = 1'b1;
                end else if (vs_start) begin
                    if (frame_ok) begin
                        state_nx = LOCKED;
                    end else begin
                        state_nx = SEARCH;
                        err_nx   = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (line_fail || (vs_start && !frame_ok)) begin
                    state_nx = SEARCH;
                    err_nx   = 1'b1;
                end
            end
            default: begin
                state_nx = SEARCH;
            end
        endcase
    end

    logic active;

    always_comb begin
        locked = (state == LOCKED);
        active = locked
               && (h_cnt >= H_A0) && (h_cnt < H_A1)
               && (v_cnt >= V_A0) && (v_cnt < V_A1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timing_err <= 1'b0;
        end else begin
            timing_err <= err_nx;
        end
    end

    // Coordinates hold their last value outside the active area
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= active;
            pix_rgb     <= active ? rgb_d : 3'b000;
            line_start  <= active && (h_cnt == H_A0);
            frame_start <= active && (h_cnt == H_A0) && (v_cnt == V_A0);
            if (active) begin
                pix_x <= h_cnt - H_A0;
                pix_y <= v_cnt - V_A0;
            end
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (timing_err && (err_count != 8'hff)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_rx_capture.sv
// Scoreboard bench for vga_rx_capture on a scaled-down raster: a line/frame
// level reference model predicts pixels and lock status, a monitor checks them.
module tb_vga_rx_capture;

    localparam int HT  = 40;
    localparam int HS  = 4;
    localparam int HB  = 4;
    localparam int HA  = 24;
    localparam int VT  = 20;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int VA  = 12;
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;

    logic       clk;
    logic       reset;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       vga_red;
    logic       vga_green;
    logic       vga_blue;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [2:0] pix_rgb;
    logic       line_start;
    logic       frame_start;
    logic       locked;
    logic       timing_err;
`ifdef VGA_RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    vga_rx_capture #(
        .H_TOTAL (HT),
        .H_SYNC  (HS),
        .H_BP    (HB),
        .H_ACTIVE(HA),
        .V_TOTAL (VT),
        .V_SYNC  (VS),
        .V_BP    (VB),
        .V_ACTIVE(VA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .vga_red    (vga_red),
        .vga_green  (vga_green),
        .vga_blue   (vga_blue),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .line_start (line_start),
        .frame_start(frame_start),
        .locked     (locked),
        .timing_err (timing_err)
`ifdef VGA_RX_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       x;
        int       y;
        logic [2:0] rgb;
        bit       ls;
        bit       fs;
        int       due;
    } pix_t;

    typedef struct {
        bit lk;
        bit er;
        int due;
    } stat_t;

    pix_t  pq[$];
    stat_t sq[$];
    pix_t  p;
    stat_t s;

    int vectors = 0;
    int miscompares = 0;
    int err_model = 0;
    int err_seen = 0;
    int n_valid = 0;

    // Reference model: position within line/frame and lock progress
    bit m_prev_hs;
    bit m_prev_vs;
    int m_h;
    int m_v;
    int m_phase;

    task automatic model_reset();
        m_prev_hs = 1'b0;
        m_prev_vs = 1'b0;
        m_h = 0;
        m_v = 0;
        m_phase = 0;
        err_model = 0;
    endtask

    task automatic model_step(bit hs, bit vs, logic [2:0] rgb, int k);
        bit fall;
        bit err;
        bit line_ok;
        bit frame_ok;
        bit vstart;
        fall = m_prev_hs && !hs;
        err = 1'b0;
        if (fall) begin
            line_ok  = (m_h + 1 == HT);
            frame_ok = (m_v + 1 == VT);
            vstart   = m_prev_vs && !vs;
            if (m_phase != 0 && !line_ok) begin
                m_phase = 0;
                err = 1'b1;
            end else if (vstart) begin
                if (m_phase == 0) m_phase = 1;
                else if (frame_ok) m_phase = 2;
                else begin
                    m_phase = 0;
                    err = 1'b1;
                end
            end
            m_prev_vs = vs;
            m_h = 0;
            m_v = vstart ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
        m_prev_hs = hs;
        if (err) err_model++;
        sq.push_back('{lk: (m_phase == 2), er: err, due: k + 2});
        if (m_phase == 2 && m_h >= HA0 && m_h < HA0 + HA
            && m_v >= VA0 && m_v < VA0 + VA) begin
            pq.push_back('{x: m_h - HA0, y: m_v - VA0, rgb: rgb,
                           ls: (m_h == HA0),
                           fs: (m_h == HA0 && m_v == VA0),
                           due: k + 3});
        end
    endtask

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic put(bit hs, bit vs, logic [2:0] rgb);
        vga_hsync = hs;
        vga_vsync = vs;
        {vga_red, vga_green, vga_blue} = rgb;
        @(posedge clk);
        #1;
        model_step(hs, vs, rgb, cyc);
    endtask

    // Red follows column parity; green/blue are random
    task automatic send_line(int len, bit vs, int stop_h);
        int hs_w;
        logic [1:0] gb;
        hs_w = (len / 2 < HS) ? len / 2 : HS;
        for (int h = 0; h < len; h++) begin
            if (h == stop_h) return;
            gb = 2'($urandom);
            put(h >= hs_w, vs, {h[0], gb});
        end
    endtask

    task automatic send_frame(int nl, int bad_v);
        for (int v = 0; v < nl; v++) begin
            send_line((v == bad_v) ? HT - 1 : HT, v >= VS, -1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_zero",
            int'({pix_valid, pix_x, pix_y, pix_rgb, line_start,
                  frame_start, locked, timing_err}), 0);
`ifdef VGA_RX_ERR_CNT_EN
        chk("reset_err_count", int'(err_count), 0);
`endif
        pq.delete();
        sq.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            err_seen = 0;
        end else begin
            if (timing_err) err_seen++;
            if (sq.size() > 0 && sq[0].due <= cyc) begin
                s = sq.pop_front();
                vectors++;
                if (locked !== s.lk || timing_err !== s.er || s.due != cyc) begin
                    miscompares++;
                    $display("FAIL status @%0d: locked=%b err=%b, expected locked=%b err=%b (due %0d)",
                             cyc, locked, timing_err, s.lk, s.er, s.due);
                end
            end
            if (pix_valid) begin
                n_valid++;
                vectors++;
                if (pq.size() == 0) begin
                    miscompares++;
                    $display("FAIL pixel @%0d: unexpected valid x=%0d y=%0d, expected none",
                             cyc, pix_x, pix_y);
                end else begin
                    p = pq.pop_front();
                    if (int'(pix_x) != p.x || int'(pix_y) != p.y || pix_rgb !== p.rgb
                        || line_start !== p.ls || frame_start !== p.fs || p.due != cyc) begin
                        miscompares++;
                        $display("FAIL pixel @%0d: got x=%0d y=%0d rgb=%b ls=%b fs=%b, expected x=%0d y=%0d rgb=%b ls=%b fs=%b at %0d",
                                 cyc, pix_x, pix_y, pix_rgb, line_start, frame_start,
                                 p.x, p.y, p.rgb, p.ls, p.fs, p.due);
                    end
                end
            end else begin
                if (pq.size() > 0 && pq[0].due <= cyc) begin
                    p = pq.pop_front();
                    vectors++;
                    miscompares++;
                    $display("FAIL pixel_missing @%0d: got no valid, expected x=%0d y=%0d",
                             cyc, p.x, p.y);
                end
                if (pix_rgb != 3'b000 || line_start || frame_start) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL gating @%0d: got rgb=%b ls=%b fs=%b, expected all 0",
                             cyc, pix_rgb, line_start, frame_start);
                end
            end
        end
    end

    int c0;

    initial begin
        reset = 1'b0;
        vga_hsync = 1'b1;
        vga_vsync = 1'b1;
        {vga_red, vga_green, vga_blue} = 3'b000;
        model_reset();
        #2;
        do_reset();

        send_line(HT, 1'b1, -1);
        send_line(HT, 1'b1, -1);
        send_frame(VT, -1);
        chk("not_locked_verify", int'(locked), 0);
        c0 = n_valid;
        send_frame(VT, -1);
        chk("frame_pixels", n_valid - c0, HA * VA);
        send_frame(VT, -1);
        chk("locked_clean", int'(locked), 1);

        send_frame(VT, 7);
        chk("short_line_unlock", int'(locked), 0);
        send_frame(VT, -1);
        send_frame(VT, -1);
        chk("relock_after_line", int'(locked), 1);

        send_frame(VT, 3);
        send_frame(VT - 1, -1);
        send_frame(VT, -1);
        chk("short_frame_no_lock", int'(locked), 0);
        send_frame(VT, -1);

        for (int v = 0; v < 10; v++) begin
            send_line(HT, v >= VS, -1);
        end
        chk("locked_before_reset", int'(locked), 1);
        send_line(HT, 1'b1, 20);
        do_reset();

        send_line(HT, 1'b1, -1);
        send_line(HT, 1'b1, -1);
        send_frame(VT, -1);
        send_frame(VT, -1);
        send_frame(VT, -1);
        chk("relock_after_reset", int'(locked), 1);

        for (int i = 0; i < 320; i++) begin
            send_line(8, 1'b1, -1);
            send_line(8, 1'b0, -1);
        end
        send_line(HT, 1'b1, -1);
        send_line(HT, 1'b1, -1);
        repeat (4) @(posedge clk);
        #1;
        chk("err_pulses", err_seen, err_model);
        chk("pixel_queue_empty", pq.size(), 0);
`ifdef VGA_RX_ERR_CNT_EN
        chk("err_count_sat", int'(err_count), (err_model > 255) ? 255 : err_model);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
